logic_reduce_unit: RTL and testbench



---
 rtl/logic_pkg.sv | 24 ++
 rtl/logic_op_apply.sv | 25 ++
 rtl/logic_reduce_unit.sv | 166 ++++++++++++++++
 tb/tb_logic_reduce_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the logic reduction unit: op encodings, FSM states
// and the helper that says which ops invert their folded result.
package logic_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_PASS    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  function automatic logic op_inverts(input logic [2:0] op_sel);
    return (op_sel == OP_NAND) || (op_sel == OP_NOR) || (op_sel == OP_XNOR);
  endfunction

endpackage

// File: rtl/logic_op_apply.sv
// Combinational base operation of one fold step. Inverting ops fold with
// their non-inverted base; the illegal op folds as OR.
module logic_op_apply
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a | b;
    unique case (op)
      OP_AND, OP_NAND:          y = a & b;
      OP_OR, OP_NOR, OP_ILLEGAL: y = a | b;
      OP_XOR, OP_XNOR:          y = a ^ b;
      OP_PASS:                  y = b;
      default:                  y = a | b;
    endcase
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Streaming bitwise reduction of a variable-length operand stream.
// Optional out_ones popcount output is enabled by LOGIC_REDUCE_POPCOUNT_EN.
module logic_reduce_unit
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MAX_OPERANDS = 16,
  localparam int unsigned CW          = $clog2(MAX_OPERANDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc,
  output logic             out_err
`ifdef LOGIC_REDUCE_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CW-1:0]    res_cnt_q, res_cnt_d;
  logic             res_trunc_q, res_trunc_d;
  logic             res_err_q, res_err_d;

  logic             beat;
  logic             finish;
  logic             trunc;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] applied;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_next;

  logic_op_apply #(
    .WIDTH(WIDTH)
  ) u_op_apply (
    .a (acc_q),
    .b (in_data),
    .op(op_q),
    .y (applied)
  );

  // in_ready depends on state only, never on out_ready.
  assign in_ready  = (state_q != StDone);
  assign out_valid = (state_q == StDone);
  assign beat      = in_valid && in_ready;

  // The first beat of an operation uses the live op input; later beats use the latched one.
  assign op_eff   = (state_q == StIdle) ? op : op_q;
  assign acc_next = (state_q == StIdle) ? in_data : applied;
  assign cnt_next = (state_q == StIdle) ? CW'(1) : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_cnt_d   = res_cnt_q;
    res_trunc_d = res_trunc_q;
    res_err_d   = res_err_q;
    finish      = 1'b0;
    trunc       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (beat) begin
          op_d    = op;
          acc_d   = acc_next;
          cnt_d   = cnt_next;
          finish  = in_last;
          state_d = in_last ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (beat) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          if (in_last || (cnt_next == CW'(MAX_OPERANDS))) begin
            finish  = 1'b1;
            trunc   = !in_last;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Inversion happens once, when the result is captured.
    if (finish) begin
      res_data_d  = op_inverts(op_eff) ? ~acc_next : acc_next;
      res_cnt_d   = cnt_next;
      res_trunc_d = trunc;
      res_err_d   = (op_eff == OP_ILLEGAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OP_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
      res_trunc_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
      res_trunc_q <= res_trunc_d;
      res_err_q   <= res_err_d;
    end
  end

  assign out_data  = res_data_q;
  assign out_count = res_cnt_q;
  assign out_trunc = res_trunc_q;
  assign out_err   = res_err_q;

`ifdef LOGIC_REDUCE_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (finish) begin
      ones_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        ones_d = ones_d + {{($clog2(WIDTH+1)-1){1'b0}}, res_data_d[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign out_ones = ones_q;
`endif

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit (WIDTH=8, MAX_OPERANDS=4).
module tb_logic_reduce_unit;

  localparam int unsigned W   = 8;
  localparam int unsigned MAX = 4;
  localparam int unsigned CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;
  logic          out_err;
`ifdef LOGIC_REDUCE_POPCOUNT_EN
  logic [$clog2(W+1)-1:0] out_ones;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] count;
    logic          trunc;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  logic_reduce_unit #(
    .WIDTH       (W),
    .MAX_OPERANDS(MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_trunc(out_trunc),
    .out_err  (out_err)
`ifdef LOGIC_REDUCE_POPCOUNT_EN
    ,
    .out_ones (out_ones)
`endif
  );

  always #5 clk = ~clk;

  // Retired results are popped and compared here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%h count=%0d with empty scoreboard",
                 out_data, out_count);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data, e.data);
        end
        checks++;
        if (out_count !== e.count) begin
          errors++;
          $display("FAIL out_count: got %0d expected %0d", out_count, e.count);
        end
        checks++;
        if (out_trunc !== e.trunc) begin
          errors++;
          $display("FAIL out_trunc: got %b expected %b", out_trunc, e.trunc);
        end
        checks++;
        if (out_err !== e.err) begin
          errors++;
          $display("FAIL out_err: got %b expected %b", out_err, e.err);
        end
`ifdef LOGIC_REDUCE_POPCOUNT_EN
        checks++;
        if (out_ones !== $countones(e.data)) begin
          errors++;
          $display("FAIL out_ones: got %0d expected %0d", out_ones, $countones(e.data));
        end
`endif
      end
    end
  end

  function automatic exp_t mk(input logic [W-1:0] d, input int c, input logic t, input logic e);
    exp_t r;
    r.data  = d;
    r.count = CW'(c);
    r.trunc = t;
    r.err   = e;
    return r;
  endfunction

  // Reference fold for random operations (at most MAX beats, always ending with last).
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] b[4],
                                         input int n);
    logic [W-1:0] r;
    r = b[0];
    for (int i = 1; i < n; i++) begin
      case (o)
        3'd0, 3'd3: r = r & b[i];
        3'd2, 3'd5: r = r ^ b[i];
        3'd6:       r = b[i];
        default:    r = r | b[i];
      endcase
    end
    if (o == 3'd3 || o == 3'd4 || o == 3'd5) r = ~r;
    return r;
  endfunction

  task automatic drive_beat(input logic [2:0] o, input logic [W-1:0] d, input logic l);
    int n = 0;
    op = o;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_data !== '0 || out_count !== '0 || out_trunc !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h count=%0d trunc=%b err=%b, required all 0",
               out_data, out_count, out_trunc, out_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_or_latency();
    exp_q.push_back(mk(8'h83, 3, 1'b0, 1'b0));
    drive_beat(3'd1, 8'h01, 1'b0);
    drive_beat(3'd1, 8'h02, 1'b0);
    drive_beat(3'd1, 8'h80, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL or_latency: out_valid=%b one cycle after last beat, required 1", out_valid);
    end
    drain();
  endtask

  task automatic test_invert_ops();
    exp_q.push_back(mk(8'hCF, 2, 1'b0, 1'b0));
    drive_beat(3'd3, 8'hF0, 1'b0);
    drive_beat(3'd3, 8'h3C, 1'b1);
    exp_q.push_back(mk(8'h5A, 1, 1'b0, 1'b0));
    drive_beat(3'd5, 8'hA5, 1'b1);
    // op changed mid-stream must be ignored: OR of 0x0F, 0xF0
    exp_q.push_back(mk(8'hFF, 2, 1'b0, 1'b0));
    drive_beat(3'd1, 8'h0F, 1'b0);
    drive_beat(3'd0, 8'hF0, 1'b1);
    exp_q.push_back(mk(8'h7E, 2, 1'b0, 1'b0));
    drive_beat(3'd0, 8'hFF, 1'b0);
    drive_beat(3'd0, 8'h7E, 1'b1);
    drain();
  endtask

  task automatic test_trunc();
    exp_q.push_back(mk(8'h0F, 4, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h10, 1, 1'b0, 1'b0));
    drive_beat(3'd2, 8'h01, 1'b0);
    drive_beat(3'd2, 8'h02, 1'b0);
    drive_beat(3'd2, 8'h04, 1'b0);
    drive_beat(3'd2, 8'h08, 1'b0);
    drive_beat(3'd2, 8'h10, 1'b1);
    drain();
  endtask

  task automatic test_err();
    exp_q.push_back(mk(8'h11, 2, 1'b0, 1'b1));
    drive_beat(3'd7, 8'h10, 1'b0);
    drive_beat(3'd7, 8'h01, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back_stall();
    int bad = 0;
    out_ready = 1'b0;
    exp_q.push_back(mk(8'h55, 1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hAA, 1, 1'b0, 1'b0));
    drive_beat(3'd1, 8'h55, 1'b1);
    op = 3'd0;
    in_data = 8'hAA;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h55) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d of 10 cycles had in_ready/out_valid/out_data wrong, required 0",
               bad);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire_no_accept: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL held_beat_accept: out_valid=%b, required 1", out_valid);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int bad = 0;
    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    drive_beat(3'd1, 8'h33, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_done: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    // Reset mid-accumulation, then a fresh single-beat op must not see stale state.
    drive_beat(3'd1, 8'h10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_accum: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_after_reset: out_valid high in %0d cycles, required 0", bad);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(mk(8'h01, 1, 1'b0, 1'b0));
    drive_beat(3'd1, 8'h01, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic [W-1:0] b[4];
    logic [2:0]   o;
    int           n;
    for (int t = 0; t < 12; t++) begin
      o = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) b[i] = W'($urandom);
      exp_q.push_back(mk(model(o, b, n), n, 1'b0, o == 3'd7));
      for (int i = 0; i < n; i++) drive_beat(o, b[i], i == n - 1);
      if (t % 3 == 0) begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_or_latency();
    test_invert_ops();
    test_trunc();
    test_err();
    test_back_to_back_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
